// File: rtl/qarctan_sched_pkg.sv
// Shared types and helpers for the qarctan scheduler.
//   ch_t   : channel id (CH0/CH1)
//   tag_t  : {valid, ch} carried alongside each issue through the core latency
//   cred_w : width needed to hold a credit count of 0..depth
package qarctan_sched_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} ch_t;

  typedef struct packed {
    logic valid;
    ch_t  ch;
  } tag_t;

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/qarctan_sched_if.sv
// Bundle of the per-channel FIFO, core and output-FIFO signals of the scheduler.
//   master : scheduler side (pops input FIFOs, issues to core, writes angles)
//   slave  : environment side (FIFOs and the qarctan core)
interface qarctan_sched_if import qarctan_sched_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  ch0_empty, ch1_empty;
  logic                  ch0_rd_en, ch1_rd_en;
  logic [DATA_WIDTH-1:0] ch0_i_dout, ch0_r_dout, ch1_i_dout, ch1_r_dout;
  logic                  core_valid_in;
  logic [DATA_WIDTH-1:0] core_i, core_r;
  logic                  core_valid_out;
  logic [DATA_WIDTH-1:0] core_angle;
  logic                  ch0_out_wr_en, ch1_out_wr_en;
  logic [DATA_WIDTH-1:0] ch0_out_din, ch1_out_din;
  logic                  ch0_out_rd_en, ch1_out_rd_en;

  modport master (
    input  ch0_empty, ch1_empty, ch0_i_dout, ch0_r_dout, ch1_i_dout, ch1_r_dout,
           core_valid_out, core_angle, ch0_out_rd_en, ch1_out_rd_en,
    output ch0_rd_en, ch1_rd_en, core_valid_in, core_i, core_r,
           ch0_out_wr_en, ch1_out_wr_en, ch0_out_din, ch1_out_din
  );

  modport slave (
    output ch0_empty, ch1_empty, ch0_i_dout, ch0_r_dout, ch1_i_dout, ch1_r_dout,
           core_valid_out, core_angle, ch0_out_rd_en, ch1_out_rd_en,
    input  ch0_rd_en, ch1_rd_en, core_valid_in, core_i, core_r,
           ch0_out_wr_en, ch1_out_wr_en, ch0_out_din, ch1_out_din
  );
endinterface

// File: rtl/qarctan_credit_ctr.sv
// Per-channel output-FIFO credit counter.
//   clock, reset : rising-edge clock, synchronous active-low reset (count -> DEPTH)
//   dec          : a sample was granted (one output slot reserved)
//   inc          : consumer popped the output FIFO (one slot returned)
//   count        : credits available
//   ovf          : sticky, a return arrived while already at DEPTH
module qarctan_credit_ctr import qarctan_sched_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int W     = cred_w(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ovf
);
  localparam logic [W-1:0] FULL = W'(DEPTH);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= FULL;
      ovf   <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: if (count == FULL) ovf <= 1'b1;
               else               count <= count + W'(1);
        // grant is only given with credit > 0; guard keeps the counter sane anyway
        2'b01: if (count != '0)   count <= count - W'(1);
        default: ;  // idle, or reserve and return in the same cycle
      endcase
    end
  end
endmodule

// File: rtl/qarctan_sched.sv
// Round-robin scheduler sharing one fixed-latency qarctan core between two
// channels. A {valid, ch} tag rides a CORE_LATENCY-deep shift register next to
// the core so each result is written to the channel that issued it.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   enable       : allow new grants (in-flight work always drains)
//   bus          : FIFO / core / output-FIFO signals (master side)
//   busy         : an issue is in flight (core input or any tag stage)
//   err          : sticky [0] orphan core result, [1] credit overflow
module qarctan_sched import qarctan_sched_pkg::*; #(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CORE_LATENCY = 8,
  parameter int OUT_DEPTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  qarctan_sched_if.master        bus,
  output logic                   busy,
  output logic [1:0]             err
);
  localparam int CW = cred_w(OUT_DEPTH);

  logic [1:0]                 empty, elig, grant, out_rd, wr_en, ovf;
  logic [1:0][DATA_WIDTH-1:0] i_head, r_head, out_din;
  logic [1:0][CW-1:0]         credit;
  logic                       core_vin, orphan;
  logic [DATA_WIDTH-1:0]      core_i, core_r;
  ch_t                        last_ch;   // channel of the most recent grant (RR pointer and issue tag)
  tag_t [CORE_LATENCY-1:0]    tag_pipe;
  tag_t                       tag_out;

  assign empty     = {bus.ch1_empty, bus.ch0_empty};
  assign out_rd    = {bus.ch1_out_rd_en, bus.ch0_out_rd_en};
  assign i_head[0] = bus.ch0_i_dout;
  assign i_head[1] = bus.ch1_i_dout;
  assign r_head[0] = bus.ch0_r_dout;
  assign r_head[1] = bus.ch1_r_dout;

  for (genvar n = 0; n < 2; n++) begin : g_ch
    // reset gates eligibility so rd_en is 0 while reset is held
    assign elig[n] = reset && enable && !empty[n] && (credit[n] != '0);

    qarctan_credit_ctr #(.DEPTH(OUT_DEPTH), .W(CW)) u_cred (
      .clock (clock),
      .reset (reset),
      .inc   (out_rd[n]),
      .dec   (grant[n]),
      .count (credit[n]),
      .ovf   (ovf[n])
    );
  end

  // Single eligible channel wins outright; on a tie the one not granted last wins.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = (last_ch == CH0) ? 2'b10 : 2'b01;
  end

  assign bus.ch0_rd_en = grant[0];
  assign bus.ch1_rd_en = grant[1];

  // Issue: operands hold their last value when idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      core_vin <= 1'b0;
      core_i   <= '0;
      core_r   <= '0;
      last_ch  <= CH1;   // ch0 wins the first tie
    end else begin
      core_vin <= |grant;
      if (|grant) begin
        last_ch <= ch_t'(grant[1]);
        core_i  <= grant[1] ? i_head[1] : i_head[0];
        core_r  <= grant[1] ? r_head[1] : r_head[0];
      end
    end
  end

  // Stage 0 captures the tag of the issue currently on the core input, so the
  // last stage lines up with core_valid_out CORE_LATENCY cycles later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= {core_vin, last_ch};
      for (int s = 1; s < CORE_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign tag_out = tag_pipe[CORE_LATENCY-1];

  // Return: a valid tag without core_valid_out is simply dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_en   <= '0;
      out_din <= '0;
      orphan  <= 1'b0;
    end else begin
      wr_en <= '0;
      if (bus.core_valid_out) begin
        if (tag_out.valid) begin
          wr_en[tag_out.ch]   <= 1'b1;
          out_din[tag_out.ch] <= bus.core_angle;
        end else begin
          orphan <= 1'b1;
        end
      end
    end
  end

  assign bus.core_valid_in = core_vin;
  assign bus.core_i        = core_i;
  assign bus.core_r        = core_r;
  assign bus.ch0_out_wr_en = wr_en[0];
  assign bus.ch1_out_wr_en = wr_en[1];
  assign bus.ch0_out_din   = out_din[0];
  assign bus.ch1_out_din   = out_din[1];

  always_comb begin
    busy = core_vin;
    for (int s = 0; s < CORE_LATENCY; s++) busy = busy | tag_pipe[s].valid;
  end

  assign err = {|ovf, orphan};
endmodule

// File: tb/tb_qarctan_sched.sv
module tb_qarctan_sched;
  import qarctan_sched_pkg::*;

  localparam int DW    = DATA_WIDTH_DEF;
  localparam int LAT   = 8;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       busy;
  logic [1:0] err;

  qarctan_sched_if #(.DATA_WIDTH(DW)) bus();

  qarctan_sched #(.DATA_WIDTH(DW), .CORE_LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .busy   (busy),
    .err    (err)
  );

  always #5 clock = ~clock;

  // ---------------- input FIFO model (FWFT) ----------------
  logic [DW-1:0] fi [2][256];
  logic [DW-1:0] fr [2][256];
  int wptr [2] = '{0, 0};
  int rptr [2] = '{0, 0};

  assign bus.ch0_empty  = (wptr[0] == rptr[0]);
  assign bus.ch1_empty  = (wptr[1] == rptr[1]);
  assign bus.ch0_i_dout = fi[0][rptr[0]];
  assign bus.ch0_r_dout = fr[0][rptr[0]];
  assign bus.ch1_i_dout = fi[1][rptr[1]];
  assign bus.ch1_r_dout = fr[1][rptr[1]];

  // ---------------- core model: angle = I ^ R after LAT cycles ----------------
  logic [LAT-1:0] mv;
  logic [DW-1:0]  md [LAT];
  logic           force_cvo = 1'b0;

  always @(posedge clock) begin
    if (!reset) mv <= '0;
    else begin
      mv    <= {mv[LAT-2:0], bus.core_valid_in};
      md[0] <= bus.core_i ^ bus.core_r;
      for (int s = 1; s < LAT; s++) md[s] <= md[s-1];
    end
  end
  assign bus.core_valid_out = mv[LAT-1] | force_cvo;
  assign bus.core_angle     = md[LAT-1];

  // ---------------- output consumer ----------------
  logic       drain = 1'b0;
  logic [1:0] man_rd = 2'b00;
  int         occ [2];
  assign bus.ch0_out_rd_en = drain ? (occ[0] > 0) : man_rd[0];
  assign bus.ch1_out_rd_en = drain ? (occ[1] > 0) : man_rd[1];

  // ---------------- monitor / logs ----------------
  int cyc = 0;
  int gn, wn0, wn1, cvo_last, busy_last;
  int gch [256], gcyc [256], wc0 [128], wc1 [128];
  logic [DW-1:0] res0 [128], res1 [128];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      gn <= 0; wn0 <= 0; wn1 <= 0;
      rptr[0] <= 0; rptr[1] <= 0;
      occ[0] <= 0; occ[1] <= 0;
      cvo_last <= -1; busy_last <= -1;
    end else begin
      if ((bus.ch0_rd_en || bus.ch1_rd_en) && gn < 256) begin
        gch[gn]  <= (bus.ch0_rd_en && bus.ch1_rd_en) ? 2 : int'(bus.ch1_rd_en);
        gcyc[gn] <= cyc;
        gn       <= gn + 1;
      end
      rptr[0] <= rptr[0] + int'(bus.ch0_rd_en);
      rptr[1] <= rptr[1] + int'(bus.ch1_rd_en);
      if (bus.ch0_out_wr_en && wn0 < 128) begin
        res0[wn0] <= bus.ch0_out_din; wc0[wn0] <= cyc; wn0 <= wn0 + 1;
      end
      if (bus.ch1_out_wr_en && wn1 < 128) begin
        res1[wn1] <= bus.ch1_out_din; wc1[wn1] <= cyc; wn1 <= wn1 + 1;
      end
      occ[0] <= occ[0] + int'(bus.ch0_out_wr_en) - int'(bus.ch0_out_rd_en);
      occ[1] <= occ[1] + int'(bus.ch1_out_wr_en) - int'(bus.ch1_out_rd_en);
      if (bus.core_valid_out) cvo_last <= cyc;
      if (busy) busy_last <= cyc;
    end
  end

  // ---------------- checking helpers ----------------
  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input int ch, input logic [DW-1:0] i, input logic [DW-1:0] r);
    if (wptr[ch] < 255) begin
      fi[ch][wptr[ch]] = i;
      fr[ch][wptr[ch]] = r;
      wptr[ch]++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; drain = 1'b0; man_rd = 2'b00; force_cvo = 1'b0;
    wptr[0] = 0; wptr[1] = 0;
    tick(3);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    int bad, bad2;
    logic [DW-1:0] e;

    // ---- reset state (inputs non-empty and enabled while reset held) ----
    @(negedge clock);
    enable = 1'b1;
    push(0, 32'h1234_5678, 32'h0000_0001);
    tick(3);
    chk("rst rd_en", 32'({bus.ch1_rd_en, bus.ch0_rd_en}), 32'd0);
    chk("rst core_valid_in", 32'(bus.core_valid_in), 32'd0);
    chk("rst core_i", bus.core_i, 32'd0);
    chk("rst wr_en", 32'({bus.ch1_out_wr_en, bus.ch0_out_wr_en}), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err), 32'd0);

    // ---- test 1: ch0 only, 5 samples, I=R -> angle 0 ----
    do_reset();
    for (int k = 0; k < 5; k++) push(0, 32'h0001_0000, 32'h0001_0000);
    enable = 1'b1;
    for (int t = 0; t < 60 && wn0 < 5; t++) tick(1);
    tick(5);
    chk("t1 grants", 32'(gn), 32'd5);
    chk("t1 ch0 writes", 32'(wn0), 32'd5);
    chk("t1 ch1 writes", 32'(wn1), 32'd0);
    bad = 0; bad2 = 0;
    for (int k = 0; k < 5; k++) begin
      if (gch[k] != 0 || res0[k] !== 32'h0) bad++;
      if (wc0[k] - gcyc[k] != LAT + 2) bad2++;
    end
    chk("t1 data/route", 32'(bad), 32'd0);
    chk("t1 latency", 32'(bad2), 32'd0);

    // ---- test 2: both channels continuously, 64 each ----
    do_reset();
    for (int k = 0; k < 64; k++) begin
      push(0, 32'h1000_0000 + 32'(k), 32'h0000_0F0F ^ (32'(k) << 4));
      push(1, 32'h2222_0000 + 32'(k * 5), 32'hFFFF_0000 | 32'(k));
    end
    drain = 1'b1;
    enable = 1'b1;
    for (int t = 0; t < 600 && !(wn0 >= 64 && wn1 >= 64); t++) tick(1);
    tick(3);
    chk("t2 grants", 32'(gn), 32'd128);
    bad = 0;
    for (int k = 0; k < 128; k++) if (gch[k] != (k % 2)) bad++;
    chk("t2 alternate", 32'(bad), 32'd0);
    chk("t2 span", 32'(gcyc[127] - gcyc[0]), 32'd127);
    chk("t2 ch0 writes", 32'(wn0), 32'd64);
    chk("t2 ch1 writes", 32'(wn1), 32'd64);
    bad = 0; bad2 = 0;
    for (int k = 0; k < 64; k++) begin
      e = (32'h1000_0000 + 32'(k)) ^ (32'h0000_0F0F ^ (32'(k) << 4));
      if (res0[k] !== e) bad++;
      e = (32'h2222_0000 + 32'(k * 5)) ^ (32'hFFFF_0000 | 32'(k));
      if (res1[k] !== e) bad2++;
    end
    chk("t2 ch0 data", 32'(bad), 32'd0);
    chk("t2 ch1 data", 32'(bad2), 32'd0);
    chk("t2 err", 32'(err), 32'd0);

    // ---- test 3: no consumer, credits run out at 8 ----
    do_reset();
    for (int k = 0; k < 20; k++) push(0, 32'(k), 32'h0);
    enable = 1'b1;
    tick(30);
    chk("t3 grants full", 32'(gn), 32'd8);
    chk("t3 rd_en held", 32'(bus.ch0_rd_en), 32'd0);
    man_rd[0] = 1'b1;
    tick(1);
    man_rd[0] = 1'b0;
    tick(20);
    chk("t3 one more grant", 32'(gn), 32'd9);
    chk("t3 writes", 32'(wn0), 32'd9);

    // ---- test 4: grant and return on ch1 in the same cycle ----
    do_reset();
    for (int k = 0; k < 20; k++) push(1, 32'h0F00 + 32'(k), 32'h00F0);
    enable = 1'b1;
    man_rd[1] = 1'b1;
    #1;
    chk("t4 same-cycle grant", 32'(bus.ch1_rd_en), 32'd1);
    tick(1);
    man_rd[1] = 1'b0;
    tick(30);
    chk("t4 grants", 32'(gn), 32'd9);
    chk("t4 err", 32'(err), 32'd0);
    // return at full credit
    do_reset();
    man_rd[1] = 1'b1;
    tick(1);
    man_rd[1] = 1'b0;
    tick(1);
    chk("t4 overflow", 32'(err), 32'd2);
    tick(10);
    chk("t4 overflow sticky", 32'(err), 32'd2);

    // ---- test 5: enable dropped after 3 grants ----
    do_reset();
    for (int k = 0; k < 10; k++) push(0, 32'h100 + 32'(k), 32'hF);
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    #1;
    chk("t5 rd_en after drop", 32'(bus.ch0_rd_en), 32'd0);
    tick(30);
    chk("t5 grants", 32'(gn), 32'd3);
    chk("t5 writes", 32'(wn0), 32'd3);
    chk("t5 last data", res0[2], 32'h10D);
    chk("t5 busy fall", 32'(busy_last - cvo_last), 32'd0);
    chk("t5 busy idle", 32'(busy), 32'd0);

    // ---- test 6: reset mid-stream, then orphan ----
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 32'hABCD_0000 + 32'(k), 32'(k));
    enable = 1'b1;
    tick(4);
    chk("t6 burst grants", 32'(gn), 32'd4);
    tick(4);
    reset = 1'b0;
    wptr[0] = 0; wptr[1] = 0;
    for (int k = 0; k < 20; k++) push(0, 32'(k + 1), 32'h0);
    tick(2);
    chk("t6 rst rd_en", 32'({bus.ch1_rd_en, bus.ch0_rd_en}), 32'd0);
    chk("t6 rst core_valid_in", 32'(bus.core_valid_in), 32'd0);
    chk("t6 rst core_i", bus.core_i, 32'd0);
    chk("t6 rst core_r", bus.core_r, 32'd0);
    chk("t6 rst wr_en", 32'({bus.ch1_out_wr_en, bus.ch0_out_wr_en}), 32'd0);
    chk("t6 rst din", bus.ch0_out_din | bus.ch1_out_din, 32'd0);
    chk("t6 rst busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick(30);
    chk("t6 credits restored", 32'(gn), 32'd8);
    chk("t6 no stale ch1", 32'(wn1), 32'd0);
    for (int t = 0; t < 50 && busy; t++) tick(1);
    chk("t6 drained", 32'(busy), 32'd0);
    force_cvo = 1'b1;
    tick(1);
    force_cvo = 1'b0;
    tick(2);
    chk("t6 orphan err", 32'(err), 32'd1);
    chk("t6 orphan no write", 32'(wn0 + wn1), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/qarctan_sched.md
Name: qarctan_sched

Overview:
- Time-shares one fixed-latency qarctan datapath core between two demod channels (ch0, ch1).
- Each channel supplies paired I/R samples from first-word-fall-through input FIFOs and receives angles into its own output FIFO.
- Round-robin arbitration; per-channel credits guarantee output FIFOs never overflow; a tag pipeline routes each result to the channel that issued it.
- Sits between the per-channel I/R FIFOs and angle FIFOs on one side and the qarctan core on the other.

Parameters:
- DATA_WIDTH, 32, width of I, R and angle words.
- CORE_LATENCY, 8, cycles from core_valid_in to the matching core_valid_out (≥1).
- OUT_DEPTH, 8, entries in each channel output FIFO; initial credit count.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = grants allowed; 0 = no new grants, in-flight work drains.
- ch0_empty, ch1_empty  in  1  input I/R FIFO pair empty.
- ch0_rd_en, ch1_rd_en  out  1  pops both I and R FIFOs of that channel.
- ch0_i_dout, ch0_r_dout, ch1_i_dout, ch1_r_dout  in  DATA_WIDTH  FWFT head data, signed.
- core_valid_in  out  1  issue strobe to core.
- core_i, core_r  out  DATA_WIDTH  operands to core.
- core_valid_out  in  1  core result valid.
- core_angle  in  DATA_WIDTH  core result.
- ch0_out_wr_en, ch1_out_wr_en  out  1  write strobe to output FIFO.
- ch0_out_din, ch1_out_din  out  DATA_WIDTH  angle to output FIFO.
- ch0_out_rd_en, ch1_out_rd_en  in  1  consumer pop of output FIFO; returns one credit.
- busy  out  1  any issue in flight.
- err  out  2  sticky: [0] orphan result (core_valid_out with no valid tag); [1] credit overflow.

Behaviour:
- Reset (reset==0 at rising edge): every output 0; credits = OUT_DEPTH each; tag pipeline cleared; RR pointer set so ch0 wins the first tie; err cleared. The core shares this reset; in-flight results are discarded.
- Eligibility: chN is eligible when enable && !chN_empty && credit_N>0.
- Grant (combinational, same cycle):
  - one eligible channel: that channel is granted;
  - both eligible: the channel not granted last is granted;
  - none eligible: no grant, pointer holds.
  - At most one grant per cycle. chN_rd_en = grant_N.
- Issue (registered): the edge after a grant drives core_valid_in=1, core_i/core_r = granted head data, tag = N. With no grant, core_valid_in=0 and core_i/core_r hold their last values.
- Tag pipeline: CORE_LATENCY stages of {valid, ch}, advancing every cycle, aligned so stage output pairs with core_valid_out.
- Return (registered): the edge after core_valid_out with a valid tag N drives chN_out_wr_en=1 and chN_out_din=core_angle; the other channel's wr_en stays 0.
- Latency from rd_en to out_wr_en: CORE_LATENCY+2 cycles. Throughput: one sample per cycle, alternating when both channels are eligible.
- Credits:
  - decrement on grant_N; increment on chN_out_rd_en;
  - both in the same cycle: unchanged;
  - increment at OUT_DEPTH: saturate and set err[1].
- Orphans: core_valid_out=1 with an invalid tag drives no write and sets err[0]. A valid tag with core_valid_out=0 is dropped silently.
- busy = OR of tag-stage valids OR core_valid_in.
- enable falling mid-stream: no grant that cycle; outstanding results still delivered.

Decomposition:
- Package qarctan_sched_pkg holds:
  - DATA_WIDTH default;
  - ch_t enum {CH0, CH1};
  - tag_t struct {logic valid; ch_t ch};
  - credit width function $clog2(OUT_DEPTH+1).
- Sub-module qarctan_credit_ctr: up/down saturating counter with overflow flag, one instance per channel.
- Arbiter, issue registers and tag pipeline live in the top module.

Test Plan:
- Only ch0 non-empty, 5 samples I=0x00010000, R=0x00010000, core model returns I^R:
  - 5 ch0 writes of 0x00000000, each CORE_LATENCY+2 cycles after its rd_en;
  - ch1_out_wr_en never asserts.
- Both channels continuously non-empty, 64 samples each:
  - grants strictly alternate ch0, ch1, …, starting with ch0 after reset;
  - 128 results, each routed to its own channel in order.
- No out_rd_en, ch0 holds 20 samples:
  - exactly 8 grants, then ch0_rd_en held 0;
  - one ch0_out_rd_en pulse → exactly one more grant.
- Grant and out_rd_en on ch1 in the same cycle → ch1 credit unchanged (checked via grant count). ch1_out_rd_en pulsed at full credit → err=2'b10 and stays set.
- enable dropped after 3 grants with CORE_LATENCY=8:
  - no further rd_en;
  - 3 results delivered;
  - busy falls 1 cycle after the last core_valid_out.
- reset asserted 4 cycles after a burst of 4 issues:
  - all outputs 0, credits 8, busy 0;
  - after release, a forced core_valid_out pulse sets err[0].
